// File: rtl/uart_tx_rx_massiv.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_rx_massiv
//  Purpose  : Full-duplex UART endpoint. TX sends an array of packs
//             back-to-back on one launch; RX collects received packs into
//             a buffer and counts the good packs and the rejected frames.
//  Ports    : IN_CLOCK / IN_RESET_N    clock, async active-low reset
//             IN_TX_DATA_MASSIV        TX packs, pack 0 in the LSBs, sent first
//             IN_TX_NUMBER_OF_PACKS_TO_SEND  packs per launch (clamped to depth)
//             IN_TX_LAUNCH             rising-edge start request
//             OUT_TX_ACTIVE / OUT_TX_DONE    burst busy / one-cycle end pulse
//             IN_RX_CLEAR_BUFFER       level clear of RX buffer, count, errors
//             OUT_RX_DATA_MASSIV       received packs, first received in LSBs
//             OUT_RX_ERROR             saturating count of rejected frames
//             OUT_RX_NUM_OF_DATA_PACKS_READY  valid packs in the buffer
//             TX_PORT / RX_PORT        serial line out (idle high) / in
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_rx_massiv #(
  parameter int UART_BAUD_RATE           = 9600,
  parameter int CLOCK_FREQUENCY          = 38400,
  parameter int PARITY                   = 1,
  parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
  parameter int NUMBER_STOP_BITS         = 1,
  parameter int TX_MASSIV_DEEP           = 2,
  parameter int RX_MASSIV_DEEP           = 2,
  parameter int TX_MASSIV_DEEP_LOG_2     = $clog2(TX_MASSIV_DEEP),
  parameter int RX_MASSIV_DEEP_LOG_2     = $clog2(RX_MASSIV_DEEP)
) (
  input  logic                                               IN_CLOCK,
  input  logic                                               IN_RESET_N,
  input  logic [NUM_OF_DATA_BITS_IN_PACK*TX_MASSIV_DEEP-1:0] IN_TX_DATA_MASSIV,
  input  logic [TX_MASSIV_DEEP_LOG_2:0]                      IN_TX_NUMBER_OF_PACKS_TO_SEND,
  input  logic                                               IN_TX_LAUNCH,
  output logic                                               OUT_TX_ACTIVE,
  output logic                                               OUT_TX_DONE,
  input  logic                                               IN_RX_CLEAR_BUFFER,
  output logic [NUM_OF_DATA_BITS_IN_PACK*RX_MASSIV_DEEP-1:0] OUT_RX_DATA_MASSIV,
  output logic [RX_MASSIV_DEEP_LOG_2:0]                      OUT_RX_ERROR,
  output logic [RX_MASSIV_DEEP_LOG_2:0]                      OUT_RX_NUM_OF_DATA_PACKS_READY,
  output logic                                               TX_PORT,
  input  logic                                               RX_PORT
);

  localparam int N   = NUM_OF_DATA_BITS_IN_PACK;
  localparam int CPB = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int CKW = $clog2(CPB);
  localparam int TCW = TX_MASSIV_DEEP_LOG_2 + 1;
  localparam int RCW = RX_MASSIV_DEEP_LOG_2 + 1;

  localparam logic [CKW-1:0] c_bit_last  = CKW'(CPB - 1);
  localparam logic [CKW-1:0] c_bit_half  = CKW'(CPB / 2 - 1);
  localparam logic [3:0]     c_data_last = 4'(N - 1);
  localparam logic [3:0]     c_stop_last = 4'(NUMBER_STOP_BITS - 1);
  localparam logic           c_odd       = (PARITY == 2);

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_DONE
  } tx_state_t;

  tx_state_t          r_tx_state, w_tx_state_next;
  logic               r_tx_launch_d;
  logic [N*TX_MASSIV_DEEP-1:0] r_tx_data;   // current pack always in the LSBs
  logic [N-1:0]       r_tx_shift;
  logic [TCW-1:0]     r_tx_packs, r_tx_idx;
  logic [CKW-1:0]     r_tx_clk;
  logic [3:0]         r_tx_bit;

  logic               w_tx_launch, w_tx_bit_end, w_tx_last_pack, w_tx_par;
  logic [TCW-1:0]     w_tx_packs_clamped;

  assign w_tx_launch        = IN_TX_LAUNCH & ~r_tx_launch_d & (r_tx_state == TX_IDLE);
  assign w_tx_packs_clamped = (IN_TX_NUMBER_OF_PACKS_TO_SEND > TCW'(TX_MASSIV_DEEP)) ?
                              TCW'(TX_MASSIV_DEEP) : IN_TX_NUMBER_OF_PACKS_TO_SEND;
  assign w_tx_bit_end       = (r_tx_clk == c_bit_last);
  assign w_tx_last_pack     = (r_tx_idx == r_tx_packs - TCW'(1));
  assign w_tx_par           = (^r_tx_data[N-1:0]) ^ c_odd;

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) r_tx_state <= TX_IDLE;
    else             r_tx_state <= w_tx_state_next;
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    TX_PORT         = 1'b1;
    OUT_TX_ACTIVE   = 1'b0;
    OUT_TX_DONE     = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_tx_launch)
          w_tx_state_next = (w_tx_packs_clamped == '0) ? TX_DONE : TX_START;
      end
      TX_START: begin
        TX_PORT       = 1'b0;
        OUT_TX_ACTIVE = 1'b1;
        if (w_tx_bit_end) w_tx_state_next = TX_DATA;
      end
      TX_DATA: begin
        TX_PORT       = r_tx_shift[0];
        OUT_TX_ACTIVE = 1'b1;
        if (w_tx_bit_end && r_tx_bit == c_data_last)
          w_tx_state_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        TX_PORT       = w_tx_par;
        OUT_TX_ACTIVE = 1'b1;
        if (w_tx_bit_end) w_tx_state_next = TX_STOP;
      end
      TX_STOP: begin
        OUT_TX_ACTIVE = 1'b1;
        if (w_tx_bit_end && r_tx_bit == c_stop_last)
          w_tx_state_next = w_tx_last_pack ? TX_DONE : TX_START;
      end
      TX_DONE: begin
        OUT_TX_DONE     = 1'b1;
        w_tx_state_next = TX_IDLE;
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      r_tx_launch_d <= 1'b0;
      r_tx_data     <= '0;
      r_tx_shift    <= '0;
      r_tx_packs    <= '0;
      r_tx_idx      <= '0;
      r_tx_clk      <= '0;
      r_tx_bit      <= '0;
    end else begin
      r_tx_launch_d <= IN_TX_LAUNCH;
      if (w_tx_launch) begin
        r_tx_data  <= IN_TX_DATA_MASSIV;
        r_tx_packs <= w_tx_packs_clamped;
        r_tx_idx   <= '0;
      end
      // Bit timers restart on every state change so each bit gets CPB clocks.
      if (w_tx_state_next != r_tx_state || w_tx_bit_end)
        r_tx_clk <= '0;
      else if (r_tx_state != TX_IDLE && r_tx_state != TX_DONE)
        r_tx_clk <= r_tx_clk + CKW'(1);
      if (w_tx_state_next != r_tx_state) r_tx_bit <= '0;
      else if (w_tx_bit_end)             r_tx_bit <= r_tx_bit + 4'd1;
      if (r_tx_state == TX_START && w_tx_bit_end)
        r_tx_shift <= r_tx_data[N-1:0];
      else if (r_tx_state == TX_DATA && w_tx_bit_end)
        r_tx_shift <= r_tx_shift >> 1;
      // Advance to the next pack once its final stop bit has been sent.
      if (r_tx_state == TX_STOP && w_tx_bit_end && r_tx_bit == c_stop_last && !w_tx_last_pack) begin
        r_tx_data <= r_tx_data >> N;
        r_tx_idx  <= r_tx_idx + TCW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  rx_state_t          r_rx_state, w_rx_state_next;
  logic               r_rx_meta, r_rx_sync, r_rx_sync_d;
  logic [CKW-1:0]     r_rx_clk;
  logic [3:0]         r_rx_bit;
  logic [N-1:0]       r_rx_shift;
  logic               r_rx_bad;
  logic [N*RX_MASSIV_DEEP-1:0] r_rx_buf;
  logic [RCW-1:0]     r_rx_cnt, r_rx_err;

  logic w_rx_fall, w_rx_half, w_rx_bit_end, w_rx_par_exp;
  logic w_rx_frame_end, w_rx_frame_ok, w_rx_frame_bad;

  assign w_rx_fall      = r_rx_sync_d & ~r_rx_sync;
  assign w_rx_half      = (r_rx_clk == c_bit_half);
  assign w_rx_bit_end   = (r_rx_clk == c_bit_last);
  assign w_rx_par_exp   = (^r_rx_shift) ^ c_odd;
  assign w_rx_frame_end = (r_rx_state == RX_STOP) && w_rx_bit_end && (r_rx_bit == c_stop_last);
  // The last stop bit is being sampled this cycle, so it is checked directly.
  assign w_rx_frame_ok  = w_rx_frame_end && !r_rx_bad && r_rx_sync;
  assign w_rx_frame_bad = w_rx_frame_end && !w_rx_frame_ok;

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) r_rx_state <= RX_IDLE;
    else             r_rx_state <= w_rx_state_next;
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:   if (w_rx_fall) w_rx_state_next = RX_START;
      // A start bit that is high again at mid-bit was a glitch.
      RX_START:  if (w_rx_half) w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_bit_end && r_rx_bit == c_data_last)
                   w_rx_state_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_bit_end) w_rx_state_next = RX_STOP;
      RX_STOP:   if (w_rx_frame_end) w_rx_state_next = RX_IDLE;
      default:   w_rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_sync_d <= 1'b1;
      r_rx_clk    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_bad    <= 1'b0;
    end else begin
      r_rx_meta   <= RX_PORT;
      r_rx_sync   <= r_rx_meta;
      r_rx_sync_d <= r_rx_sync;
      // After the mid-start check, full-bit intervals land on later mid-bits.
      if (w_rx_state_next != r_rx_state || w_rx_bit_end)
        r_rx_clk <= '0;
      else if (r_rx_state != RX_IDLE)
        r_rx_clk <= r_rx_clk + CKW'(1);
      if (w_rx_state_next != r_rx_state) r_rx_bit <= '0;
      else if (w_rx_bit_end)             r_rx_bit <= r_rx_bit + 4'd1;
      if (r_rx_state == RX_DATA && w_rx_bit_end)
        r_rx_shift <= {r_rx_sync, r_rx_shift[N-1:1]};
      if (r_rx_state == RX_IDLE)
        r_rx_bad <= 1'b0;
      else if (r_rx_state == RX_PARITY && w_rx_bit_end && r_rx_sync != w_rx_par_exp)
        r_rx_bad <= 1'b1;
      else if (r_rx_state == RX_STOP && w_rx_bit_end && !r_rx_sync)
        r_rx_bad <= 1'b1;
    end
  end

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      r_rx_buf <= '0;
      r_rx_cnt <= '0;
      r_rx_err <= '0;
    end else if (IN_RX_CLEAR_BUFFER) begin
      r_rx_buf <= '0;
      r_rx_cnt <= '0;
      r_rx_err <= '0;
    end else begin
      if (w_rx_frame_ok && r_rx_cnt != RCW'(RX_MASSIV_DEEP)) begin
        for (int k = 0; k < RX_MASSIV_DEEP; k++)
          if (r_rx_cnt == RCW'(k)) r_rx_buf[k*N +: N] <= r_rx_shift;
        r_rx_cnt <= r_rx_cnt + RCW'(1);
      end
      if (w_rx_frame_bad && r_rx_err != '1)
        r_rx_err <= r_rx_err + RCW'(1);
    end
  end

  assign OUT_RX_DATA_MASSIV             = r_rx_buf;
  assign OUT_RX_ERROR                   = r_rx_err;
  assign OUT_RX_NUM_OF_DATA_PACKS_READY = r_rx_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_rx_massiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_rx_massiv
//  Purpose  : Directed bench for a cross-wired pair of UART endpoints (A, B)
//             with 3 stop bits; B's receive line can be switched to a
//             bench-driven line to inject malformed frames.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_rx_massiv;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a_txd, b_txd;
  logic [1:0]  a_num, b_num;
  logic        a_launch, b_launch, a_clear, b_clear;
  logic        a_active, b_active, a_done, b_done, a_tx, b_tx;
  logic [15:0] a_rxd, b_rxd;
  logic [1:0]  a_err, b_err, a_cnt, b_cnt;
  logic        inj_en, inj_line, b_rx;

  assign b_rx = inj_en ? inj_line : a_tx;

  uart_tx_rx_massiv #(.NUMBER_STOP_BITS(3)) u_a (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n),
    .IN_TX_DATA_MASSIV(a_txd), .IN_TX_NUMBER_OF_PACKS_TO_SEND(a_num),
    .IN_TX_LAUNCH(a_launch), .OUT_TX_ACTIVE(a_active), .OUT_TX_DONE(a_done),
    .IN_RX_CLEAR_BUFFER(a_clear), .OUT_RX_DATA_MASSIV(a_rxd),
    .OUT_RX_ERROR(a_err), .OUT_RX_NUM_OF_DATA_PACKS_READY(a_cnt),
    .TX_PORT(a_tx), .RX_PORT(b_tx));

  uart_tx_rx_massiv #(.NUMBER_STOP_BITS(3)) u_b (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n),
    .IN_TX_DATA_MASSIV(b_txd), .IN_TX_NUMBER_OF_PACKS_TO_SEND(b_num),
    .IN_TX_LAUNCH(b_launch), .OUT_TX_ACTIVE(b_active), .OUT_TX_DONE(b_done),
    .IN_RX_CLEAR_BUFFER(b_clear), .OUT_RX_DATA_MASSIV(b_rxd),
    .OUT_RX_ERROR(b_err), .OUT_RX_NUM_OF_DATA_PACKS_READY(b_cnt),
    .TX_PORT(b_tx), .RX_PORT(b_rx));

  int vectors = 0;
  int miscompares = 0;
  int cyc, act_cnt, done_cnt, first_act, done_idx, tx_low_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    cyc = 0; act_cnt = 0; done_cnt = 0; first_act = -1; done_idx = -1; tx_low_cnt = 0;
  endtask

  // Watches one transmitter for n cycles, sampling on the falling edge.
  task automatic mon(input bit sel_b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (sel_b ? b_active : a_active) begin
        act_cnt++;
        if (first_act < 0) first_act = cyc;
      end
      if (sel_b ? b_done : a_done) begin
        done_cnt++;
        done_idx = cyc;
      end
      if ((sel_b ? b_tx : a_tx) == 1'b0) tx_low_cnt++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop);
    logic [12:0] f;
    f = {1'b1, 1'b1, ~bad_stop, (^d) ^ flip_par, d, 1'b0};
    for (int i = 0; i < 13; i++) begin
      inj_line = f[i];
      repeat (4) @(negedge clk);
    end
    inj_line = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_clear_b();
    b_clear = 1'b1;
    repeat (2) @(negedge clk);
    b_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; a_txd = '0; b_txd = '0; a_num = '0; b_num = '0;
    a_launch = 1'b0; b_launch = 1'b0; a_clear = 1'b0; b_clear = 1'b0;
    inj_en = 1'b0; inj_line = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_port", 32'(a_tx), 32'd1);
    check("rst_active",  32'(a_active), 32'd0);
    check("rst_done",    32'(a_done), 32'd0);
    check("rst_rx_data", 32'(a_rxd), 32'h0);
    check("rst_rx_cnt",  32'(a_cnt), 32'd0);
    check("rst_rx_err",  32'(a_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // A sends two packs to B.
    a_txd = 16'h026A; a_num = 2'd2; a_launch = 1'b1;
    mon_clear(); mon(1'b0, 130);
    a_launch = 1'b0;
    check("t1_first_active", 32'(first_act), 32'd1);
    check("t1_active_cycles", 32'(act_cnt), 32'd104);
    check("t1_done_pulses", 32'(done_cnt), 32'd1);
    check("t1_done_cycle", 32'(done_idx), 32'd105);
    check("t1_b_cnt", 32'(b_cnt), 32'd2);
    check("t1_b_data", 32'(b_rxd), 32'h026A);
    check("t1_b_err", 32'(b_err), 32'd0);

    // B clears, then echoes the swapped packs back to A.
    pulse_clear_b();
    check("t2_b_cnt_clr", 32'(b_cnt), 32'd0);
    check("t2_b_err_clr", 32'(b_err), 32'd0);
    check("t2_b_data_clr", 32'(b_rxd), 32'h0);
    b_txd = 16'h6A02; b_num = 2'd2; b_launch = 1'b1;
    mon_clear(); mon(1'b1, 130);
    b_launch = 1'b0;
    check("t2_b_active_cycles", 32'(act_cnt), 32'd104);
    check("t2_b_done_pulses", 32'(done_cnt), 32'd1);
    check("t2_a_cnt", 32'(a_cnt), 32'd2);
    check("t2_a_data", 32'(a_rxd), 32'h6A02);
    check("t2_a_err", 32'(a_err), 32'd0);

    // Launch held high, dropped, then raised again mid-burst: one burst only.
    a_clear = 1'b1; @(negedge clk); a_clear = 1'b0;
    a_txd = 16'hA55A; a_num = 2'd2; a_launch = 1'b1;
    mon_clear(); mon(1'b0, 10);
    a_launch = 1'b0; mon(1'b0, 5);
    a_launch = 1'b1; mon(1'b0, 5);
    a_launch = 1'b0; mon(1'b0, 130);
    check("t3_active_cycles", 32'(act_cnt), 32'd104);
    check("t3_done_pulses", 32'(done_cnt), 32'd1);
    check("t3_done_cycle", 32'(done_idx), 32'd105);
    check("t3_b_cnt", 32'(b_cnt), 32'd2);
    check("t3_b_data", 32'(b_rxd), 32'hA55A);

    // Count above depth is clamped to two packs.
    pulse_clear_b();
    a_txd = 16'h33CC; a_num = 2'd3; a_launch = 1'b1;
    mon_clear(); mon(1'b0, 130);
    a_launch = 1'b0;
    check("t3b_clamp_active", 32'(act_cnt), 32'd104);
    check("t3b_clamp_b_data", 32'(b_rxd), 32'h33CC);

    // Zero-pack launch.
    pulse_clear_b();
    a_num = 2'd0; a_launch = 1'b1;
    mon_clear(); mon(1'b0, 1);
    a_launch = 1'b0; mon(1'b0, 30);
    check("t4_active_cycles", 32'(act_cnt), 32'd0);
    check("t4_done_pulses", 32'(done_cnt), 32'd1);
    check("t4_done_cycle", 32'(done_idx), 32'd1);
    check("t4_tx_low", 32'(tx_low_cnt), 32'd0);
    check("t4_b_cnt", 32'(b_cnt), 32'd0);

    // Injected frames into B: glitch, bad parity, bad stop.
    inj_line = 1'b1; inj_en = 1'b1;
    repeat (2) @(negedge clk);
    inj_line = 1'b0; @(negedge clk); inj_line = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_glitch_err", 32'(b_err), 32'd0);
    check("t5_glitch_cnt", 32'(b_cnt), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("t5_par_err", 32'(b_err), 32'd1);
    check("t5_par_cnt", 32'(b_cnt), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1);
    check("t5_stop_err", 32'(b_err), 32'd2);
    check("t5_stop_cnt", 32'(b_cnt), 32'd0);

    // Overflow: three good packs into a two-deep buffer.
    pulse_clear_b();
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    check("t6_ovf_cnt", 32'(b_cnt), 32'd2);
    check("t6_ovf_data", 32'(b_rxd), 32'h2211);
    check("t6_ovf_err", 32'(b_err), 32'd0);

    // Reset asserted in the middle of an A frame.
    inj_en = 1'b0;
    a_txd = 16'h0000; a_num = 2'd2; a_launch = 1'b1;
    mon_clear(); mon(1'b0, 20);
    check("t7_pre_active", 32'(a_active), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t7_tx_port", 32'(a_tx), 32'd1);
    check("t7_active", 32'(a_active), 32'd0);
    check("t7_done", 32'(a_done), 32'd0);
    check("t7_b_cnt", 32'(b_cnt), 32'd0);
    check("t7_b_data", 32'(b_rxd), 32'h0);
    a_launch = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
